// File: rtl/bsg_manycore_edge_pkg.sv
// ============================================================================
// Module   : bsg_manycore_edge_pkg
// Brief    : Shared op/status encodings and packet field layout helpers for
//            the manycore edge link.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bsg_manycore_edge_pkg;

    typedef enum logic [1:0] {
        e_op_load  = 2'b00,
        e_op_store = 2'b01
    } edge_op_e;

    localparam logic [4:0] c_status_store_ack = 5'b00001;
    localparam logic [4:0] c_status_load_nack = 5'b00010;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Request layout, LSB first: dest_x, dest_y, src_x, src_y, mask, op, addr, data
    function automatic int req_packet_width(input int x_w, input int y_w,
                                            input int a_w, input int d_w);
        return 6 + 2 * (x_w + y_w) + a_w + d_w;
    endfunction

    function automatic int req_src_x_lsb(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    function automatic int req_src_y_lsb(input int x_w, input int y_w);
        return 2 * x_w + y_w;
    endfunction

    function automatic int req_op_lsb(input int x_w, input int y_w);
        return 2 * (x_w + y_w) + 4;
    endfunction

    // Return layout, LSB first: x, y, status
    function automatic int ret_packet_width(input int x_w, input int y_w);
        return 5 + x_w + y_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_manycore_edge_link_channel.sv
// ============================================================================
// Module   : bsg_manycore_edge_link_channel (+ bsg_manycore_edge_link_fifo)
// Brief    : One edge channel, pass-through with credit control or terminate
//            with synthesised returns. Statistics registers are built only
//            when BSG_MANYCORE_EDGE_LINK_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_manycore_edge_link_fifo
    import bsg_manycore_edge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ELS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_v,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_v,
    input  logic             i_ready
);
    localparam int c_ptr_w = safe_clog2(ELS);
    localparam int c_cnt_w = safe_clog2(ELS + 1);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(ELS - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(ELS);

    logic [WIDTH-1:0]   r_mem [ELS];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_enq;
    logic               w_deq;

    assign o_ready = (r_count != c_full);
    assign o_v     = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_enq   = i_v & o_ready;
    assign w_deq   = o_v & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
            if (w_deq) r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
            if (w_enq & ~w_deq)      r_count <= r_count + c_cnt_w'(1);
            else if (~w_enq & w_deq) r_count <= r_count - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

module bsg_manycore_edge_link_channel
    import bsg_manycore_edge_pkg::*;
#(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int fifo_els_p        = 2,
    parameter int max_out_credits_p = 16,
    parameter bit terminate_p       = 1'b0,
    localparam int packet_width_lp     = req_packet_width(x_cord_width_p, y_cord_width_p, addr_width_p, data_width_p),
    localparam int ret_packet_width_lp = ret_packet_width(x_cord_width_p, y_cord_width_p),
    localparam int credit_width_lp     = safe_clog2(max_out_credits_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [packet_width_lp-1:0]     req_data_i,
    input  logic                           req_v_i,
    output logic                           req_ready_o,
    output logic [ret_packet_width_lp-1:0] ret_data_o,
    output logic                           ret_v_o,
    input  logic                           ret_ready_i,
    output logic [packet_width_lp-1:0]     req_data_o,
    output logic                           req_v_o,
    input  logic                           req_ready_i,
    input  logic [ret_packet_width_lp-1:0] ret_data_i,
    input  logic                           ret_v_i,
    output logic                           ret_ready_o,
    output logic [credit_width_lp-1:0]     credits_o,
    output logic [15:0]                    drop_count_o,
    output logic                           credit_err_o
);
    localparam int c_src_x_lsb = req_src_x_lsb(x_cord_width_p, y_cord_width_p);
    localparam int c_src_y_lsb = req_src_y_lsb(x_cord_width_p, y_cord_width_p);
    localparam int c_op_lsb    = req_op_lsb(x_cord_width_p, y_cord_width_p);

    logic w_req_acc;
    logic w_ret_acc;

    assign w_req_acc = req_v_i & req_ready_o;
    assign w_ret_acc = ret_v_i & ret_ready_o;

    if (terminate_p) begin : g_terminate
        logic [1:0]                     w_op;
        logic [x_cord_width_p-1:0]      w_src_x;
        logic [y_cord_width_p-1:0]      w_src_y;
        logic                           w_ret_gen;
        logic [ret_packet_width_lp-1:0] w_ret_pkt;
        logic                           w_unused;

        assign w_op      = req_data_i[c_op_lsb +: 2];
        assign w_src_x   = req_data_i[c_src_x_lsb +: x_cord_width_p];
        assign w_src_y   = req_data_i[c_src_y_lsb +: y_cord_width_p];
        // Ready comes from FIFO space alone; ops without a reply are still consumed.
        assign w_ret_gen = req_v_i & ((w_op == e_op_store) | (w_op == e_op_load));
        assign w_ret_pkt = {(w_op == e_op_store) ? c_status_store_ack : c_status_load_nack,
                            w_src_y, w_src_x};

        bsg_manycore_edge_link_fifo #(
            .WIDTH (ret_packet_width_lp),
            .ELS   (fifo_els_p)
        ) u_ret_fifo (
            .clk     (clk_i),
            .rst     (reset_i),
            .i_data  (w_ret_pkt),
            .i_v     (w_ret_gen),
            .o_ready (req_ready_o),
            .o_data  (ret_data_o),
            .o_v     (ret_v_o),
            .i_ready (ret_ready_i)
        );

        assign req_data_o   = '0;
        assign req_v_o      = 1'b0;
        assign ret_ready_o  = 1'b1;
        assign credits_o    = '0;
        assign credit_err_o = 1'b0;
        assign w_unused     = ^{req_ready_i, ret_v_i, ret_data_i, req_data_i, w_req_acc, w_ret_acc};

`ifdef BSG_MANYCORE_EDGE_LINK_STATS_EN
        logic [15:0] r_drop_count;

        always_ff @(posedge clk_i) begin
            if (reset_i)                                     r_drop_count <= '0;
            else if (w_req_acc && r_drop_count != 16'hFFFF)  r_drop_count <= r_drop_count + 16'd1;
        end

        assign drop_count_o = r_drop_count;
`else
        assign drop_count_o = '0;
`endif
    end else begin : g_pass
        localparam logic [credit_width_lp-1:0] c_max_credits = credit_width_lp'(max_out_credits_p);

        logic [credit_width_lp-1:0] r_credits;
        logic                       w_credit_ok;
        logic                       w_req_fifo_ready;
        logic                       w_at_max;

        assign w_credit_ok = (r_credits != '0);
        assign w_at_max    = (r_credits == c_max_credits);
        assign req_ready_o = w_req_fifo_ready & w_credit_ok;

        bsg_manycore_edge_link_fifo #(
            .WIDTH (packet_width_lp),
            .ELS   (fifo_els_p)
        ) u_req_fifo (
            .clk     (clk_i),
            .rst     (reset_i),
            .i_data  (req_data_i),
            .i_v     (req_v_i & w_credit_ok),
            .o_ready (w_req_fifo_ready),
            .o_data  (req_data_o),
            .o_v     (req_v_o),
            .i_ready (req_ready_i)
        );

        bsg_manycore_edge_link_fifo #(
            .WIDTH (ret_packet_width_lp),
            .ELS   (fifo_els_p)
        ) u_ret_fifo (
            .clk     (clk_i),
            .rst     (reset_i),
            .i_data  (ret_data_i),
            .i_v     (ret_v_i),
            .o_ready (ret_ready_o),
            .o_data  (ret_data_o),
            .o_v     (ret_v_o),
            .i_ready (ret_ready_i)
        );

        // A request and a return in the same cycle cancel out.
        always_ff @(posedge clk_i) begin
            if (reset_i)                               r_credits <= c_max_credits;
            else if (w_req_acc & ~w_ret_acc)           r_credits <= r_credits - credit_width_lp'(1);
            else if (w_ret_acc & ~w_req_acc & ~w_at_max) r_credits <= r_credits + credit_width_lp'(1);
        end

        assign credits_o    = r_credits;
        assign drop_count_o = '0;

`ifdef BSG_MANYCORE_EDGE_LINK_STATS_EN
        logic r_credit_err;

        always_ff @(posedge clk_i) begin
            if (reset_i)                               r_credit_err <= 1'b0;
            else if (w_ret_acc & ~w_req_acc & w_at_max) r_credit_err <= 1'b1;
        end

        assign credit_err_o = r_credit_err;
`else
        assign credit_err_o = 1'b0;
`endif
    end
endmodule

`default_nettype wire

// File: rtl/bsg_manycore_edge_link.sv
// ============================================================================
// Module   : bsg_manycore_edge_link
// Brief    : Edge adapter of num_links_p request/return channel pairs, each
//            pass-through or terminate. Stats: BSG_MANYCORE_EDGE_LINK_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_manycore_edge_link
    import bsg_manycore_edge_pkg::*;
#(
    parameter int num_links_p       = 4,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int fifo_els_p        = 2,
    parameter int max_out_credits_p = 16,
    parameter logic [num_links_p-1:0] terminate_p = '0,
    localparam int packet_width_lp     = req_packet_width(x_cord_width_p, y_cord_width_p, addr_width_p, data_width_p),
    localparam int ret_packet_width_lp = ret_packet_width(x_cord_width_p, y_cord_width_p),
    localparam int credit_width_lp     = safe_clog2(max_out_credits_p + 1)
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic [num_links_p-1:0][packet_width_lp-1:0]     req_data_i,
    input  logic [num_links_p-1:0]                          req_v_i,
    output logic [num_links_p-1:0]                          req_ready_o,
    output logic [num_links_p-1:0][ret_packet_width_lp-1:0] ret_data_o,
    output logic [num_links_p-1:0]                          ret_v_o,
    input  logic [num_links_p-1:0]                          ret_ready_i,
    output logic [num_links_p-1:0][packet_width_lp-1:0]     req_data_o,
    output logic [num_links_p-1:0]                          req_v_o,
    input  logic [num_links_p-1:0]                          req_ready_i,
    input  logic [num_links_p-1:0][ret_packet_width_lp-1:0] ret_data_i,
    input  logic [num_links_p-1:0]                          ret_v_i,
    output logic [num_links_p-1:0]                          ret_ready_o,
    output logic [num_links_p-1:0][credit_width_lp-1:0]     credits_o,
    output logic [num_links_p-1:0][15:0]                    drop_count_o,
    output logic [num_links_p-1:0]                          credit_err_o
);
    for (genvar i = 0; i < num_links_p; i++) begin : g_link
        bsg_manycore_edge_link_channel #(
            .x_cord_width_p    (x_cord_width_p),
            .y_cord_width_p    (y_cord_width_p),
            .addr_width_p      (addr_width_p),
            .data_width_p      (data_width_p),
            .fifo_els_p        (fifo_els_p),
            .max_out_credits_p (max_out_credits_p),
            .terminate_p       (terminate_p[i])
        ) u_channel (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .req_data_i   (req_data_i[i]),
            .req_v_i      (req_v_i[i]),
            .req_ready_o  (req_ready_o[i]),
            .ret_data_o   (ret_data_o[i]),
            .ret_v_o      (ret_v_o[i]),
            .ret_ready_i  (ret_ready_i[i]),
            .req_data_o   (req_data_o[i]),
            .req_v_o      (req_v_o[i]),
            .req_ready_i  (req_ready_i[i]),
            .ret_data_i   (ret_data_i[i]),
            .ret_v_i      (ret_v_i[i]),
            .ret_ready_o  (ret_ready_o[i]),
            .credits_o    (credits_o[i]),
            .drop_count_o (drop_count_o[i]),
            .credit_err_o (credit_err_o[i])
        );
    end
endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_edge_link.sv
// ============================================================================
// Module   : tb_bsg_manycore_edge_link
// Brief    : Bench for the edge link: link 0 pass-through, link 1 terminate,
//            checked against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_manycore_edge_link;
    localparam int NL = 2;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int FE = 2;
    localparam int MC = 4;
    localparam int PW = 6 + 2 * (XW + YW) + AW + DW;
    localparam int RW = 5 + XW + YW;
    localparam int CW = $clog2(MC + 1);
    localparam int SX_LSB = XW + YW;
    localparam int SY_LSB = 2 * XW + YW;
    localparam int OP_LSB = 2 * (XW + YW) + 4;
`ifdef BSG_MANYCORE_EDGE_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [PW-1:0] pkt_t;
    typedef logic [RW-1:0] rpkt_t;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [NL-1:0][PW-1:0]  req_data_i, req_data_o;
    logic [NL-1:0]          req_v_i, req_ready_o, req_v_o, req_ready_i;
    logic [NL-1:0][RW-1:0]  ret_data_o, ret_data_i;
    logic [NL-1:0]          ret_v_o, ret_ready_i, ret_v_i, ret_ready_o;
    logic [NL-1:0][CW-1:0]  credits_o;
    logic [NL-1:0][15:0]    drop_count_o;
    logic [NL-1:0]          credit_err_o;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    pkt_t  m_req_q[$];
    rpkt_t m_ret_q[$];
    rpkt_t m_tret_q[$];
    int    m_cred;
    int    m_drop;
    bit    m_err;

    always #5 clk_i = ~clk_i;

    bsg_manycore_edge_link #(
        .num_links_p       (NL),
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .addr_width_p      (AW),
        .data_width_p      (DW),
        .fifo_els_p        (FE),
        .max_out_credits_p (MC),
        .terminate_p       (2'b10)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_data_i   (req_data_i),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .ret_data_o   (ret_data_o),
        .ret_v_o      (ret_v_o),
        .ret_ready_i  (ret_ready_i),
        .req_data_o   (req_data_o),
        .req_v_o      (req_v_o),
        .req_ready_i  (req_ready_i),
        .ret_data_i   (ret_data_i),
        .ret_v_i      (ret_v_i),
        .ret_ready_o  (ret_ready_o),
        .credits_o    (credits_o),
        .drop_count_o (drop_count_o),
        .credit_err_o (credit_err_o)
    );

    function automatic pkt_t make_req(input logic [1:0] op, input logic [XW-1:0] sx, input logic [YW-1:0] sy);
        pkt_t p;
        p = pkt_t'({$urandom, $urandom});
        p[OP_LSB +: 2]  = op;
        p[SX_LSB +: XW] = sx;
        p[SY_LSB +: YW] = sy;
        return p;
    endfunction

    function automatic bit m_p_req_ready();
        return (m_req_q.size() < FE) && (m_cred != 0);
    endfunction

    function automatic bit m_p_ret_ready();
        return m_ret_q.size() < FE;
    endfunction

    function automatic bit m_t_req_ready();
        return m_tret_q.size() < FE;
    endfunction

    task automatic model_reset();
        m_req_q.delete();
        m_ret_q.delete();
        m_tret_q.delete();
        m_cred = MC;
        m_drop = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        bit   a_req, a_ret, a_treq;
        pkt_t p;
        a_req  = req_v_i[0] && m_p_req_ready();
        a_ret  = ret_v_i[0] && m_p_ret_ready();
        a_treq = req_v_i[1] && m_t_req_ready();
        if (m_req_q.size() != 0 && req_ready_i[0])  void'(m_req_q.pop_front());
        if (m_ret_q.size() != 0 && ret_ready_i[0])  void'(m_ret_q.pop_front());
        if (m_tret_q.size() != 0 && ret_ready_i[1]) void'(m_tret_q.pop_front());
        if (a_req) m_req_q.push_back(req_data_i[0]);
        if (a_ret) m_ret_q.push_back(ret_data_i[0]);
        if (a_req && !a_ret) m_cred--;
        else if (a_ret && !a_req) begin
            if (m_cred == MC) m_err = 1'b1;
            else              m_cred++;
        end
        if (a_treq) begin
            p = req_data_i[1];
            if (m_drop < 65535) m_drop++;
            if (p[OP_LSB +: 2] == 2'b01)      m_tret_q.push_back({5'b00001, p[SY_LSB +: YW], p[SX_LSB +: XW]});
            else if (p[OP_LSB +: 2] == 2'b00) m_tret_q.push_back({5'b00010, p[SY_LSB +: YW], p[SX_LSB +: XW]});
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_v_i     = '0;
        ret_v_i     = '0;
        req_data_i  = '0;
        ret_data_i  = '0;
        req_ready_i = '1;
        ret_ready_i = '1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        n_vec++;
        if ({req_v_o, ret_v_o, req_ready_o, ret_ready_o} !== 8'b00_00_11_11) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 00001111", {req_v_o, ret_v_o, req_ready_o, ret_ready_o});
        end
        n_vec++;
        if (credits_o[0] !== CW'(MC) || credits_o[1] !== CW'(0)) begin
            n_fail++;
            $display("FAIL reset_credits got %0d/%0d want %0d/0", credits_o[0], credits_o[1], MC);
        end
        n_vec++;
        if (drop_count_o !== '0 || credit_err_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_stats got drop %h err %b want 0", drop_count_o, credit_err_o);
        end
    endtask

    task automatic test_pass_basic();
        logic [RW-1:0] r;
        idle_inputs();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_v_i[0]    = 1'b1;
            req_data_i[0] = make_req(2'b01, XW'($urandom), YW'($urandom));
            n_vec++;
            if (credits_o[0] !== CW'(MC - k) || req_ready_o[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL pass_credit k=%0d got cred %0d rdy %b want %0d 1", k, credits_o[0], req_ready_o[0], MC - k);
            end
            if (k > 0) begin
                n_vec++;
                if (req_v_o[0] !== 1'b1 || m_req_q.size() == 0 || req_data_o[0] !== m_req_q[0]) begin
                    n_fail++;
                    $display("FAIL pass_fwd k=%0d got v %b data %h", k, req_v_o[0], req_data_o[0]);
                end
            end
            cycle();
        end
        n_vec++;
        if (credits_o[0] !== CW'(0) || req_ready_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_empty got cred %0d rdy %b want 0 0", credits_o[0], req_ready_o[0]);
        end
        cycle();
        req_v_i[0]    = 1'b0;
        ret_v_i[0]    = 1'b1;
        r             = RW'($urandom);
        ret_data_i[0] = r;
        cycle();
        ret_v_i[0] = 1'b0;
        n_vec++;
        if (credits_o[0] !== CW'(1) || req_ready_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_return got cred %0d rdy %b want 1 1", credits_o[0], req_ready_o[0]);
        end
        n_vec++;
        if (ret_v_o[0] !== 1'b1 || ret_data_o[0] !== r) begin
            n_fail++;
            $display("FAIL pass_ret_fwd got v %b data %h want 1 %h", ret_v_o[0], ret_data_o[0], r);
        end
        cycle();
    endtask

    task automatic test_simultaneous();
        pkt_t          p;
        logic [RW-1:0] r;
        idle_inputs();
        do_reset();
        req_v_i[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_data_i[0] = make_req(2'b01, XW'($urandom), YW'($urandom));
            cycle();
        end
        p             = make_req(2'b00, XW'($urandom), YW'($urandom));
        r             = RW'($urandom);
        req_data_i[0] = p;
        ret_v_i[0]    = 1'b1;
        ret_data_i[0] = r;
        cycle();
        idle_inputs();
        n_vec++;
        if (credits_o[0] !== CW'(2)) begin
            n_fail++;
            $display("FAIL simul_credits got %0d want 2", credits_o[0]);
        end
        n_vec++;
        if (req_v_o[0] !== 1'b1 || req_data_o[0] !== p || ret_v_o[0] !== 1'b1 || ret_data_o[0] !== r) begin
            n_fail++;
            $display("FAIL simul_fwd got %b %h %b %h want 1 %h 1 %h", req_v_o[0], req_data_o[0], ret_v_o[0], ret_data_o[0], p, r);
        end
        cycle();
    endtask

    task automatic test_terminate();
        rpkt_t exp_ret [2];
        idle_inputs();
        do_reset();
        exp_ret[0] = {5'b00001, 2'd1, 2'd3};
        exp_ret[1] = {5'b00010, 2'd2, 2'd0};
        for (int k = 0; k < 5; k++) begin
            req_v_i[1] = (k < 3);
            if (k == 0)      req_data_i[1] = make_req(2'b01, 2'd3, 2'd1);
            else if (k == 1) req_data_i[1] = make_req(2'b00, 2'd0, 2'd2);
            else             req_data_i[1] = make_req(2'b11, XW'($urandom), YW'($urandom));
            n_vec++;
            if (req_v_o[1] !== 1'b0 || ret_ready_o[1] !== 1'b1 || credits_o[1] !== CW'(0)) begin
                n_fail++;
                $display("FAIL term_static k=%0d got reqv %b retrdy %b cred %0d", k, req_v_o[1], ret_ready_o[1], credits_o[1]);
            end
            n_vec++;
            if ((k == 1 || k == 2) ? (ret_v_o[1] !== 1'b1 || ret_data_o[1] !== exp_ret[k-1]) : (ret_v_o[1] !== 1'b0)) begin
                n_fail++;
                $display("FAIL term_ret k=%0d got v %b data %h", k, ret_v_o[1], ret_data_o[1]);
            end
            cycle();
        end
        n_vec++;
        if (drop_count_o[1] !== (STATS ? 16'd3 : 16'd0)) begin
            n_fail++;
            $display("FAIL term_drop got %0d want %0d", drop_count_o[1], STATS ? 3 : 0);
        end
    endtask

    task automatic test_backpressure();
        rpkt_t exp_q[$];
        pkt_t  p;
        idle_inputs();
        do_reset();
        ret_ready_i[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p             = make_req(2'($urandom_range(0, 1)), XW'($urandom), YW'($urandom));
            req_v_i[1]    = 1'b1;
            req_data_i[1] = p;
            n_vec++;
            if (req_ready_o[1] !== (k < FE)) begin
                n_fail++;
                $display("FAIL bp_ready k=%0d got %b want %b", k, req_ready_o[1], k < FE);
            end
            if (k > 0) begin
                n_vec++;
                if (ret_v_o[1] !== 1'b1 || ret_data_o[1] !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold k=%0d got v %b data %h", k, ret_v_o[1], ret_data_o[1]);
                end
            end
            if (k < FE)
                exp_q.push_back({(p[OP_LSB +: 2] == 2'b01) ? 5'b00001 : 5'b00010, p[SY_LSB +: YW], p[SX_LSB +: XW]});
            cycle();
        end
        req_v_i[1]     = 1'b0;
        ret_ready_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ((k < FE) ? (ret_v_o[1] !== 1'b1 || ret_data_o[1] !== exp_q[k]) : (ret_v_o[1] !== 1'b0)) begin
                n_fail++;
                $display("FAIL bp_drain k=%0d got v %b data %h", k, ret_v_o[1], ret_data_o[1]);
            end
            cycle();
        end
    endtask

    task automatic test_credit_overflow();
        logic [RW-1:0] r;
        idle_inputs();
        do_reset();
        r             = RW'($urandom);
        ret_v_i[0]    = 1'b1;
        ret_data_i[0] = r;
        cycle();
        ret_v_i[0] = 1'b0;
        n_vec++;
        if (credits_o[0] !== CW'(MC) || credit_err_o[0] !== STATS || ret_v_o[0] !== 1'b1 || ret_data_o[0] !== r) begin
            n_fail++;
            $display("FAIL ovf got cred %0d err %b v %b data %h want %0d %b 1 %h", credits_o[0], credit_err_o[0], ret_v_o[0], ret_data_o[0], MC, STATS, r);
        end
        for (int k = 0; k < 3; k++) cycle();
        n_vec++;
        if (credit_err_o[0] !== STATS) begin
            n_fail++;
            $display("FAIL ovf_sticky got %b want %b", credit_err_o[0], STATS);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_ctl, obs_ctl;
        idle_inputs();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_v_i       = 2'($urandom);
            ret_v_i[0]    = ($urandom_range(0, 2) == 0);
            ret_v_i[1]    = 1'($urandom);
            req_data_i[0] = make_req(2'($urandom), XW'($urandom), YW'($urandom));
            req_data_i[1] = make_req(2'($urandom), XW'($urandom), YW'($urandom));
            ret_data_i    = {RW'($urandom), RW'($urandom)};
            req_ready_i   = 2'($urandom);
            ret_ready_i   = 2'($urandom);
            exp_ctl = {m_p_req_ready(), m_p_ret_ready(), m_req_q.size() != 0, m_ret_q.size() != 0,
                       m_t_req_ready(), 1'b0, 1'b1, m_tret_q.size() != 0};
            obs_ctl = {req_ready_o[0], ret_ready_o[0], req_v_o[0], ret_v_o[0],
                       req_ready_o[1], req_v_o[1], ret_ready_o[1], ret_v_o[1]};
            n_vec++;
            if (obs_ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl c=%0d got %b want %b", c, obs_ctl, exp_ctl);
            end
            n_vec++;
            if (credits_o[0] !== CW'(m_cred) || credit_err_o[0] !== (STATS & m_err) ||
                drop_count_o[1] !== (STATS ? 16'(m_drop) : 16'd0)) begin
                n_fail++;
                $display("FAIL rand_status c=%0d got cred %0d err %b drop %0d want %0d %b %0d", c, credits_o[0], credit_err_o[0], drop_count_o[1], m_cred, STATS & m_err, STATS ? m_drop : 0);
            end
            if (m_req_q.size() != 0) begin
                n_vec++;
                if (req_data_o[0] !== m_req_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_req_data c=%0d got %h want %h", c, req_data_o[0], m_req_q[0]);
                end
            end
            if (m_ret_q.size() != 0) begin
                n_vec++;
                if (ret_data_o[0] !== m_ret_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_ret_data c=%0d got %h want %h", c, ret_data_o[0], m_ret_q[0]);
                end
            end
            if (m_tret_q.size() != 0) begin
                n_vec++;
                if (ret_data_o[1] !== m_tret_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_term_data c=%0d got %h want %h", c, ret_data_o[1], m_tret_q[0]);
                end
            end
            cycle();
        end
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        do_reset();
        req_ready_i   = 2'b00;
        ret_ready_i   = 2'b00;
        req_v_i       = 2'b11;
        ret_v_i[0]    = 1'b1;
        req_data_i[0] = make_req(2'b01, XW'($urandom), YW'($urandom));
        req_data_i[1] = make_req(2'b01, XW'($urandom), YW'($urandom));
        ret_data_i[0] = RW'($urandom);
        cycle();
        cycle();
        n_vec++;
        if ({req_v_o[0], ret_v_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_fill got %b want 111", {req_v_o[0], ret_v_o});
        end
        idle_inputs();
        do_reset();
        n_vec++;
        if ({req_v_o, ret_v_o, req_ready_o, ret_ready_o} !== 8'b00_00_11_11 || credits_o[0] !== CW'(MC)) begin
            n_fail++;
            $display("FAIL mid_reset got ctl %b cred %0d want 00001111 %0d", {req_v_o, ret_v_o, req_ready_o, ret_ready_o}, credits_o[0], MC);
        end
        n_vec++;
        if (drop_count_o !== '0 || credit_err_o !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_stats got drop %h err %b want 0", drop_count_o, credit_err_o);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_pass_basic();
        test_simultaneous();
        test_terminate();
        test_backpressure();
        test_credit_overflow();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bsg_manycore_edge_link.md
# bsg_manycore_edge_link

Parametrised edge adapter for one side of the manycore mesh, carrying `num_links_p` independent request/return channel pairs between the array boundary and the outside. Each channel is built as either pass-through or terminate.
- **Pass-through:** buffered forwarding with outstanding-request credit control.
- **Terminate:** sinks requests at an unused edge and synthesises return packets, so cores never hang waiting for responses.

The block replaces constant-tied edge return inputs on the array perimeter.

## Interface
Parameters:
- `num_links_p`, "inv": channel count (rows for E/W edge, columns for N/S edge).
- `x_cord_width_p`, "inv": x coordinate width.
- `y_cord_width_p`, "inv": y coordinate width.
- `addr_width_p`, "inv": request address width.
- `data_width_p`, "inv": request data width.
- `fifo_els_p`, 2: depth of every per-channel FIFO, ≥2.
- `max_out_credits_p`, 16: outstanding-request limit per pass-through channel.
- `terminate_p`, {num_links_p{1'b0}}: bit i=1 builds channel i as terminate.
- `packet_width_lp`: 6+2*(x+y)+addr+data.
- `ret_packet_width_lp`: 5+x+y.
- `credit_width_lp`: `BSG_SAFE_CLOG2(max_out_credits_p+1)`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i` in 1: clock.
  - `reset_i` in 1: synchronous active-high reset.
- Array-facing request input, from tiles:
  - `req_data_i` in [num_links_p][packet_width_lp].
  - `req_v_i` in [num_links_p].
  - `req_ready_o` out [num_links_p].
- Array-facing return output, to tiles:
  - `ret_data_o` out [num_links_p][ret_packet_width_lp].
  - `ret_v_o` out [num_links_p].
  - `ret_ready_i` in [num_links_p].
- Outside request output:
  - `req_data_o` out [num_links_p][packet_width_lp].
  - `req_v_o` out [num_links_p].
  - `req_ready_i` in [num_links_p].
- Outside return input:
  - `ret_data_i` in [num_links_p][ret_packet_width_lp].
  - `ret_v_i` in [num_links_p].
  - `ret_ready_o` out [num_links_p].
- Status:
  - `credits_o` out [num_links_p][credit_width_lp]: available credits.
  - `drop_count_o` out [num_links_p][16]: terminated-request count.
  - `credit_err_o` out [num_links_p]: sticky credit overflow.

## Operation
- Request packet fields, MSB→LSB: data, addr, op[1:0], mask[3:0], src_y, src_x, dest_y, dest_x.
- Return packet fields, MSB→LSB: status[4:0], y, x.
- Handshakes: a transfer occurs when v and ready are both high in the same cycle. Ready outputs do not depend combinationally on v inputs.
- Pass-through channel:
  - Request path: FIFO into `req_*_o`. Return path: FIFO into `ret_*_o`.
  - Credit counter resets to `max_out_credits_p`.
    - Decrements on each accepted request (`req_v_i & req_ready_o`).
    - Increments on each accepted return (`ret_v_i & ret_ready_o`).
    - Both in the same cycle: counter unchanged.
  - `req_ready_o` = request FIFO not full AND credits≠0.
  - Return arriving with credits already at max: counter stays at max and `credit_err_o` sets. The packet is still forwarded.
- Terminate channel:
  - `req_v_o`=0 and `ret_ready_o`=1; `ret_data_i` is ignored.
  - Op decoding:
    - op=01 (store): return {STATUS_STORE_ACK=5'b00001, src_y, src_x}.
    - op=00 (load): return {STATUS_LOAD_NACK=5'b00010, src_y, src_x}.
    - op=10/11: no return.
  - `req_ready_o` = return FIFO not full, regardless of op.
  - Every accepted request increments `drop_count_o`, which saturates at 16'hFFFF.
  - `credits_o` reads 0.

## Timing
- Reset values of outputs:
  - `req_v_o`=0 and `ret_v_o`=0.
  - `drop_count_o`=0 and `credit_err_o`=0.
  - `credits_o` = max (pass-through) or 0 (terminate).
  - `req_ready_o` = 1 (pass-through) or 1 (terminate).
  - `ret_ready_o` = 1.
- Reset mid-operation: all FIFOs flush and all counters return to their reset values in the next cycle. No packet in flight survives.
- Latency:
  - Pass-through: one cycle, input to output. A packet accepted at cycle t is presented at t+1.
  - Terminate: a return for a request accepted at t appears at t+1.
- Full FIFO: ready low. While `fifo_els_p` is not reached, a simultaneous enqueue and dequeue sustains one packet per cycle.
- Empty FIFO: v low.
- Output v and data stay stable while ready is low.

## Configuration
- `BSG_MANYCORE_EDGE_LINK_STATS_EN` defined: `drop_count_o` and `credit_err_o` are implemented as specified.
- Macro absent: the counter and flag registers are removed and both ports are tied to 0. Credit saturation still clamps silently.

## Structure
- Package `bsg_manycore_edge_pkg` holds:
  - Op encodings: `e_op_load`, `e_op_store`.
  - Status constants.
  - Field offset/width functions for the request and return layouts.
- Sub-module `bsg_manycore_edge_link_channel`: one channel, with the mode selected by a scalar `terminate_p`. The top level is a generate loop of `num_links_p` instances.

## Test plan
- **Pass-through basic:** with `max_out_credits_p`=4 and `req_ready_i`=1, send 4 stores and return 0 → `credits_o` 4→0, `req_ready_o`=0 on the 5th. One return → credit 1 and acceptance resumes next cycle.
- **Simultaneous events:** accept a request and a return in the same cycle at credits=2 → credits stay 2, with both packets appearing at t+1.
- **Terminate:** store src (x=3,y=1), then load src (x=0,y=2), then op=11.
  - `ret_data_o` = {00001,1,3}, then {00010,2,0}, with no third return.
  - `drop_count_o`=3; `req_v_o` never high.
- **Backpressure:** terminate channel with `ret_ready_i`=0 and `fifo_els_p`=2 → exactly 2 requests accepted, then `req_ready_o`=0. Releasing `ret_ready_i` drains them in order.
- **Credit overflow:** return injected at credits=max → credits stay max and `credit_err_o`=1 sticky until reset.
- **Reset mid-flight:** FIFOs half full, assert `reset_i` one cycle → all v low, `credits_o`=max, counts 0 next cycle.
